// File: rtl/rom_read_arbiter.sv
// ============================================================================
// Module   : rom_read_arbiter
// Brief    : Round-robin arbiter sharing one combinational lookup ROM among
//            NUM_REQ requesters. Define ROM_ARB_ADDR_CHECK_EN to add rd_err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_read_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 10,
    parameter int ROM_DEPTH = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [ADDR_W-1:0]           rom_addr,
    input  logic [DATA_W-1:0]           rom_data,
    output logic                        rd_valid,
    output logic [$clog2(NUM_REQ)-1:0]  rd_id,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        busy
`ifdef ROM_ARB_ADDR_CHECK_EN
    ,
    output logic                        rd_err
`endif
);

    localparam int                 c_id_w     = $clog2(NUM_REQ);
    localparam int                 c_sw       = c_id_w + 1;
    localparam logic [c_id_w-1:0]  c_last_rst = c_id_w'(NUM_REQ - 1);
    localparam logic [0:0]         c_idle     = 1'b0;
    localparam logic [0:0]         c_read     = 1'b1;

    logic [0:0]          r_state, w_state_nxt;
    logic [NUM_REQ-1:0]  r_gnt, w_gnt_nxt;
    logic [ADDR_W-1:0]   r_rom_addr, w_rom_addr_nxt;
    logic                r_rd_valid, w_rd_valid_nxt;
    logic [c_id_w-1:0]   r_rd_id, w_rd_id_nxt;
    logic [DATA_W-1:0]   r_rd_data, w_rd_data_nxt;
    logic                r_busy, w_busy_nxt;
    logic [c_id_w-1:0]   r_last, w_last_nxt;
    logic                w_addr_bad;

    logic [ADDR_W-1:0]   w_addr_arr [NUM_REQ];
    logic                w_found;
    logic [c_id_w-1:0]   w_win;
    logic [c_sw-1:0]     w_sum;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    end

    // Scan starting just after the previous winner so it gets lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_last} + c_sw'(1) + c_sw'(i);
            if (w_sum >= c_sw'(NUM_REQ)) begin
                w_sum = w_sum - c_sw'(NUM_REQ);
            end
            if (!w_found && req[w_sum[c_id_w-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[c_id_w-1:0];
            end
        end
    end

`ifdef ROM_ARB_ADDR_CHECK_EN
    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(ROM_DEPTH);
    logic r_rd_err, w_rd_err_nxt;
    assign w_addr_bad = ({1'b0, r_rom_addr} >= c_depth);
    assign rd_err     = r_rd_err;
`else
    assign w_addr_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_idle;
            r_gnt      <= '0;
            r_rom_addr <= '0;
            r_rd_valid <= 1'b0;
            r_rd_id    <= '0;
            r_rd_data  <= '0;
            r_busy     <= 1'b0;
            r_last     <= c_last_rst;
`ifdef ROM_ARB_ADDR_CHECK_EN
            r_rd_err   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_rom_addr <= w_rom_addr_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_rd_id    <= w_rd_id_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_busy     <= w_busy_nxt;
            r_last     <= w_last_nxt;
`ifdef ROM_ARB_ADDR_CHECK_EN
            r_rd_err   <= w_rd_err_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (w_found) w_state_nxt = c_read;
            c_read:  w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    always_comb begin
        w_gnt_nxt      = '0;
        w_rom_addr_nxt = r_rom_addr;
        w_rd_valid_nxt = 1'b0;
        w_rd_id_nxt    = r_rd_id;
        w_rd_data_nxt  = r_rd_data;
        w_busy_nxt     = 1'b0;
        w_last_nxt     = r_last;
`ifdef ROM_ARB_ADDR_CHECK_EN
        w_rd_err_nxt   = 1'b0;
`endif
        if (r_state == c_idle) begin
            if (w_found) begin
                w_gnt_nxt[w_win] = 1'b1;
                w_rom_addr_nxt   = w_addr_arr[w_win];
                w_rd_id_nxt      = w_win;
                w_last_nxt       = w_win;
                w_busy_nxt       = 1'b1;
            end
        end else begin
            // Out-of-range words are suppressed; address is still on the bus.
            w_rd_data_nxt  = w_addr_bad ? '0 : rom_data;
            w_rd_valid_nxt = 1'b1;
`ifdef ROM_ARB_ADDR_CHECK_EN
            w_rd_err_nxt   = w_addr_bad;
`endif
        end
    end

    assign gnt      = r_gnt;
    assign rom_addr = r_rom_addr;
    assign rd_valid = r_rd_valid;
    assign rd_id    = r_rd_id;
    assign rd_data  = r_rd_data;
    assign busy     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_rom_read_arbiter.sv
// ============================================================================
// Module   : tb_rom_read_arbiter
// Brief    : Directed self-checking bench for rom_read_arbiter (4 requesters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_read_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_addr;
    logic [3:0]  gnt;
    logic [3:0]  rom_addr;
    logic [9:0]  rom_data;
    logic        rd_valid;
    logic [1:0]  rd_id;
    logic [9:0]  rd_data;
    logic        busy;
`ifdef ROM_ARB_ADDR_CHECK_EN
    logic        rd_err;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // ROM model: populated pattern is 0x100 | address.
    assign rom_data = 10'h100 | {6'b0, rom_addr};

    rom_read_arbiter #(
        .NUM_REQ   (4),
        .ADDR_W    (4),
        .DATA_W    (10),
        .ROM_DEPTH (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .gnt      (gnt),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rd_valid (rd_valid),
        .rd_id    (rd_id),
        .rd_data  (rd_data),
        .busy     (busy)
`ifdef ROM_ARB_ADDR_CHECK_EN
        ,
        .rd_err   (rd_err)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        req      = 4'b0000;
        req_addr = 16'h0000;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_rd_id", 32'(rd_id), 32'h0);
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;

        // Idle: nothing should move.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_outs", {28'h0, gnt}, 32'h0);
            chk("idle_flags", {30'h0, busy, rd_valid}, 32'h0);
        end

        // Single read from requester 2 at address 7.
        req      = 4'b0100;
        req_addr = 16'h0700;
        tick();
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_busy", 32'(busy), 32'h1);
        chk("single_rom_addr", 32'(rom_addr), 32'h7);
        req      = 4'b0000;
        req_addr = 16'h0000;   // must not disturb the latched address
        tick();
        chk("single_gnt_off", 32'(gnt), 32'h0);
        chk("single_valid", 32'(rd_valid), 32'h1);
        chk("single_id", 32'(rd_id), 32'h2);
        chk("single_data", 32'(rd_data), 32'h107);
        chk("single_busy_off", 32'(busy), 32'h0);
`ifdef ROM_ARB_ADDR_CHECK_EN
        chk("single_err", 32'(rd_err), 32'h0);
`endif
        tick();
        chk("single_valid_off", 32'(rd_valid), 32'h0);

        // Fairness: 3 wins alone, then 0 and 3 both ask -> 0 then 3.
        req_addr = 16'h4321;
        req      = 4'b1000;
        tick();
        chk("fair_gnt3", 32'(gnt), 32'h8);
        req = 4'b1001;          // arrives during READ, ignored until IDLE
        tick();
        chk("fair_rd3_data", 32'(rd_data), 32'h104);
        chk("fair_rd3_id", 32'(rd_id), 32'h3);
        chk("fair_rd3_gnt", 32'(gnt), 32'h0);
        tick();
        chk("fair_gnt0", 32'(gnt), 32'h1);
        tick();
        chk("fair_rd0_data", 32'(rd_data), 32'h101);
        tick();
        chk("fair_gnt3b", 32'(gnt), 32'h8);
        tick();
        chk("fair_rd3b_id", 32'(rd_id), 32'h3);

        // All requesting: rotation 0,1,2,3,0, a result every second cycle.
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_gnt", 32'(gnt), 32'h1 << (k % 4));
            chk("rr_valid_low", 32'(rd_valid), 32'h0);
            tick();
            chk("rr_valid", 32'(rd_valid), 32'h1);
            chk("rr_id", 32'(rd_id), 32'(k % 4));
            chk("rr_data", 32'(rd_data), 32'h101 + 32'(k % 4));
        end
        req = 4'b0000;
        tick();

        // Reset during READ kills the read and the round-robin pointer.
        req = 4'b0011;
        tick();
        chk("mid_gnt_pre", 32'(gnt), 32'h2);
        rst = 1'b1;
        tick();
        chk("mid_valid", 32'(rd_valid), 32'h0);
        chk("mid_gnt", 32'(gnt), 32'h0);
        chk("mid_data", 32'(rd_data), 32'h0);
        chk("mid_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        tick();
        chk("mid_gnt_post", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick();
        chk("mid_rd_id", 32'(rd_id), 32'h0);
        chk("mid_rd_data", 32'(rd_data), 32'h101);
        tick();

        // Address beyond populated depth.
        req_addr = 16'h432C;
        req      = 4'b0001;
        tick();
        chk("oob_rom_addr", 32'(rom_addr), 32'hC);
        chk("oob_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick();
        chk("oob_valid", 32'(rd_valid), 32'h1);
`ifdef ROM_ARB_ADDR_CHECK_EN
        chk("oob_err", 32'(rd_err), 32'h1);
        chk("oob_data", 32'(rd_data), 32'h0);
`else
        chk("oob_data", 32'(rd_data), 32'h10C);
`endif
        tick();
        chk("oob_valid_off", 32'(rd_valid), 32'h0);
`ifdef ROM_ARB_ADDR_CHECK_EN
        chk("oob_err_off", 32'(rd_err), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
